// File: rtl/seg_scan_driver_if.sv
// Write port bundle for seg_scan_driver.
// Game logic (master) pushes 16-bit hex + 4 dp bits; driver (slave) reports pending.
`timescale 1ns/1ps
interface seg_scan_driver_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        pending;

  modport master (
    output wr_en,
    output wr_data,
    output wr_dp,
    input  pending
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  wr_dp,
    output pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed common-anode 7-seg driver, double-buffered data.
// Ports: clk, rst (async high), en, tick, wr (write bus), frame_done, an, seg, dp.
`timescale 1ns/1ps
module seg_scan_driver #(
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                tick,
  seg_scan_driver_if.slave    wr,
  output logic                frame_done,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam logic [7:0] BLANK = 8'(BLANK_CYC);

  logic [1:0]  dig,  dig_n;
  logic [7:0]  bcnt, bcnt_n;
  logic [15:0] pdat, pdat_n;
  logic [3:0]  pdp,  pdp_n;
  logic        pv,   pv_n;
  logic [15:0] adat, adat_n;
  logic [3:0]  adp,  adp_n;
  logic        fd_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    dig_n  = dig;
    bcnt_n = bcnt;
    pdat_n = pdat;
    pdp_n  = pdp;
    pv_n   = pv;
    adat_n = adat;
    adp_n  = adp;
    fd_n   = 1'b0;
    if (bcnt != 8'd0)
      bcnt_n = bcnt - 8'd1;
    if (!en) begin
      dig_n  = 2'd0;
      bcnt_n = BLANK;
    end else if (tick) begin
      dig_n  = dig + 2'd1;
      bcnt_n = BLANK;
      if (dig == 2'd3) begin
        fd_n = 1'b1;
        if (pv) begin
          adat_n = pdat;
          adp_n  = pdp;
          pv_n   = 1'b0;
        end
      end
    end
    // A write on the wrap tick lands after the commit above,
    // so the old buffer is shown and the new one stays pending.
    if (wr.wr_en) begin
      pdat_n = wr.wr_data;
      pdp_n  = wr.wr_dp;
      pv_n   = 1'b1;
    end
  end

  // Outputs are registered from next-state so the panel
  // reflects a tick in the very next cycle.
  always_comb begin
    nib   = adat_n[{dig_n, 2'b00} +: 4];
    seg_n = hex7(nib);
    dp_n  = ~adp_n[dig_n];
    if (!en || bcnt_n != 8'd0)
      an_n = 4'hF;
    else
      an_n = ~(4'b0001 << dig_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig        <= 2'd0;
      bcnt       <= BLANK;
      pdat       <= 16'h0;
      pdp        <= 4'h0;
      pv         <= 1'b0;
      adat       <= 16'h0;
      adp        <= 4'h0;
      frame_done <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      dig        <= dig_n;
      bcnt       <= bcnt_n;
      pdat       <= pdat_n;
      pdp        <= pdp_n;
      pv         <= pv_n;
      adat       <= adat_n;
      adp        <= adp_n;
      frame_done <= fd_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
    end
  end

  assign wr.pending = pv;

endmodule
